// File: rtl/online_mult_sequencer_if.sv
// Operand, multiplier-digit and result bundle for online_mult_sequencer.
// ONLINE_SEQ_DIGCHK_EN adds the illegal-digit flag err.
interface online_mult_sequencer_if #(
  parameter int NO_OF_DIGITS = 4,
  parameter int RADIX_BITS   = 3
);
  localparam int NRB = NO_OF_DIGITS * RADIX_BITS;

  logic                  in_valid;
  logic                  in_ready;
  logic [NRB-1:0]        in_x;
  logic [NRB-1:0]        in_y;
  logic                  in_full;
  logic                  mul_clear;
  logic [RADIX_BITS-1:0] mul_x;
  logic [RADIX_BITS-1:0] mul_y;
  logic [RADIX_BITS-1:0] mul_z;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*NRB-1:0]      out_z;
  logic                  out_full;
`ifdef ONLINE_SEQ_DIGCHK_EN
  logic                  err;
`endif

  modport slave (
    input  in_valid, in_x, in_y, in_full, mul_z, out_ready,
    output in_ready, mul_clear, mul_x, mul_y, out_valid, out_z, out_full
`ifdef ONLINE_SEQ_DIGCHK_EN
    , output err
`endif
  );

  modport master (
    output in_valid, in_x, in_y, in_full, mul_z, out_ready,
    input  in_ready, mul_clear, mul_x, mul_y, out_valid, out_z, out_full
`ifdef ONLINE_SEQ_DIGCHK_EN
    , input err
`endif
  );
endinterface

// File: rtl/online_mult_sequencer.sv
// Feeds one radix-4 online multiplier MSD-first from parallel operands and
// collects its digit stream into a parallel product. Optional ONLINE_SEQ_DIGCHK_EN.
// S_IDLE  | waiting for an operand pair (in_ready=1)
// S_CLEAR | one cycle of mul_clear with zero digits
// S_RUN   | step k: stream digit k, capture mul_z into out_z digit k-DELTA
// S_DONE  | result presented until out_ready
module online_mult_sequencer #(
  parameter int NO_OF_DIGITS = 4,
  parameter int RADIX_BITS   = 3,
  parameter int DELTA        = 2
) (
  input logic clk,
  input logic reset,
  online_mult_sequencer_if.slave bus
);
  localparam int N   = NO_OF_DIGITS;
  localparam int RB  = RADIX_BITS;
  localparam int NRB = N * RB;
  localparam int SW  = $clog2(2 * N + DELTA + 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [SW-1:0]   r_step, w_step_nxt;
  logic [NRB-1:0]  r_xs, r_ys;
  logic [2*NRB-1:0] r_z;
  logic            r_full;
  logic            r_in_ready, r_mul_clear, r_out_valid;
  logic [RB-1:0]   r_mul_x, r_mul_y;
  logic            w_accept, w_hshk, w_last, w_zwr;
  int              w_m;
`ifdef ONLINE_SEQ_DIGCHK_EN
  logic            r_err;
  logic            w_bad;
`endif

  always_comb begin
    w_accept = bus.in_valid && r_in_ready;
    w_hshk   = bus.out_ready && r_out_valid;
    w_m      = r_full ? 2 * N : N;
    w_last   = (int'(r_step) == DELTA + w_m - 1);
    w_zwr    = (r_state == S_RUN) && (int'(r_step) >= DELTA) && (int'(r_step) < DELTA + w_m);
  end

`ifdef ONLINE_SEQ_DIGCHK_EN
  // -4 has no positive counterpart in the multiplier's digit set
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bus.in_x[i*RB +: RB] == {1'b1, {(RB-1){1'b0}}}) w_bad = 1'b1;
      if (bus.in_y[i*RB +: RB] == {1'b1, {(RB-1){1'b0}}}) w_bad = 1'b1;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef ONLINE_SEQ_DIGCHK_EN
          w_state_nxt = w_bad ? S_DONE : S_CLEAR;
`else
          w_state_nxt = S_CLEAR;
`endif
        end
      end
      S_CLEAR: begin
        w_state_nxt = S_RUN;
        w_step_nxt  = '0;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
        else        w_step_nxt  = r_step + SW'(1);
      end
      S_DONE: begin
        if (w_hshk) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_step      <= '0;
      r_xs        <= '0;
      r_ys        <= '0;
      r_z         <= '0;
      r_full      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_mul_clear <= 1'b0;
      r_out_valid <= 1'b0;
      r_mul_x     <= '0;
      r_mul_y     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_step      <= w_step_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_mul_clear <= (w_state_nxt == S_CLEAR);
      r_out_valid <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_xs   <= bus.in_x;
        r_ys   <= bus.in_y;
        r_full <= bus.in_full;
        r_z    <= '0;
      end
      if (w_state_nxt == S_RUN) begin
        r_mul_x <= r_xs[NRB-1 -: RB];
        r_mul_y <= r_ys[NRB-1 -: RB];
        r_xs    <= r_xs << RB;
        r_ys    <= r_ys << RB;
      end else begin
        r_mul_x <= '0;
        r_mul_y <= '0;
      end
      for (int d = 0; d < 2 * N; d++) begin
        if (w_zwr && (int'(r_step) - DELTA == d)) r_z[(2*N-1-d)*RB +: RB] <= bus.mul_z;
      end
    end
  end

`ifdef ONLINE_SEQ_DIGCHK_EN
  always_ff @(posedge clk) begin
    if (reset)                   r_err <= 1'b0;
    else if (w_accept && w_bad)  r_err <= 1'b1;
    else if (w_hshk)             r_err <= 1'b0;
  end
  assign bus.err = r_err;
`endif

  assign bus.in_ready  = r_in_ready;
  assign bus.mul_clear = r_mul_clear;
  assign bus.mul_x     = r_mul_x;
  assign bus.mul_y     = r_mul_y;
  assign bus.out_valid = r_out_valid;
  assign bus.out_z     = r_z;
  assign bus.out_full  = r_full;
endmodule

// File: tb/tb_online_mult_sequencer.sv
// Scoreboard bench for online_mult_sequencer: a mock multiplier replays known
// product digits, a monitor checks each result handshake against the queue.
module tb_online_mult_sequencer;
  localparam int N = 4, RB = 3, DELTA = 2, NRB = N * RB, ZW = 2 * NRB;

  logic clk = 1'b0;
  logic reset;

  online_mult_sequencer_if #(.NO_OF_DIGITS(N), .RADIX_BITS(RB)) bus ();
  online_mult_sequencer #(.NO_OF_DIGITS(N), .RADIX_BITS(RB), .DELTA(DELTA)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ZW-1:0] z;
    logic          full;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int cx[N], cy[N], pd[2*N];
  int n_cmp = 0, n_bad = 0;
  int m_step = -1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [RB-1:0] dig(int v);
    logic [31:0] t;
    t = v;
    return t[RB-1:0];
  endfunction

  function automatic logic [ZW-1:0] pack_z(bit full);
    logic [ZW-1:0] z;
    int m;
    z = '0;
    m = full ? 2 * N : N;
    for (int j = 0; j < m; j++) z[(2*N-1-j)*RB +: RB] = dig(pd[j]);
    return z;
  endfunction

  function automatic logic [NRB-1:0] pack_op(bit is_y);
    logic [NRB-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[(N-1-i)*RB +: RB] = is_y ? dig(cy[i]) : dig(cx[i]);
    return v;
  endfunction

  // Exact product scaled by 4^(2N), written as sign-magnitude radix-4 digits
  function automatic void model_pd();
    longint p, a;
    p = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        p += longint'(cx[i] * cy[j]) * (longint'(1) << (2 * (2*N - 2 - i - j)));
    a = (p < 0) ? -p : p;
    for (int j = 2*N - 1; j >= 0; j--) begin
      pd[j] = int'(a % 4);
      if (p < 0) pd[j] = -pd[j];
      a = a / 4;
    end
  endfunction

  // Mock online multiplier: checks streamed digits, replays pd after DELTA steps
  always @(negedge clk) begin
    if (reset || bus.in_ready) begin
      m_step    = -1;
      bus.mul_z = '0;
    end else if (bus.mul_clear) begin
      m_step    = 0;
      bus.mul_z = '0;
    end else if (m_step >= 0) begin
      if (m_step < N + DELTA) begin
        check("mul_x", bus.mul_x, (m_step < N) ? dig(cx[m_step]) : '0);
        check("mul_y", bus.mul_y, (m_step < N) ? dig(cy[m_step]) : '0);
      end
      bus.mul_z = (m_step >= DELTA && m_step - DELTA < 2*N) ? dig(pd[m_step - DELTA]) : '0;
      m_step++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got z=%0h with empty queue", bus.out_z);
      end else begin
        e = sb.pop_front();
        check("out_z", bus.out_z, e.z);
        check("out_full", bus.out_full, e.full);
`ifdef ONLINE_SEQ_DIGCHK_EN
        check("err", bus.err, e.err);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(bit full, bit bad, bit early);
    int n;
    exp_t e;
    n = 0;
    while (!bus.in_ready && n < 50) begin tick(); n++; end
    check("idle_wait", (n < 50), 1);
    e.z = bad ? '0 : pack_z(full);
    e.full = full;
    e.err = bad;
    sb.push_back(e);
    bus.in_x = pack_op(0);
    bus.in_y = pack_op(1);
    bus.in_full = full;
    bus.in_valid = 1'b1;
    bus.out_ready = early;
    tick();
    bus.in_valid = 1'b0;
    check("clear", bus.mul_clear, !bad);
    check("busy", bus.in_ready, 0);
  endtask

  task automatic run_op(bit full, bit bad, bit early, int hold);
    int n;
    logic [ZW-1:0] zs;
    issue(full, bad, early);
    n = 1;
    while (!bus.out_valid && n < 40) begin tick(); n++; end
    check("latency", n, bad ? 1 : 2 + DELTA + (full ? 2*N : N));
    if (!early) begin
      zs = bus.out_z;
      for (int h = 0; h < hold; h++) begin
        bus.in_valid = 1'b1;
        bus.in_x = ~bus.in_x;
        tick();
        check("hold_z", bus.out_z, zs);
        check("hold_busy", bus.in_ready, 0);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
    end
    tick();
    bus.out_ready = 1'b0;
    check("ready_after", bus.in_ready, 1);
    check("valid_after", bus.out_valid, 0);
`ifdef ONLINE_SEQ_DIGCHK_EN
    check("err_after", bus.err, 0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_x = '0;
    bus.in_y = '0;
    bus.in_full = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_mul_clear", bus.mul_clear, 0);
    check("rst_mul_x", bus.mul_x, 0);
    check("rst_mul_y", bus.mul_y, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_z", bus.out_z, 0);
    check("rst_out_full", bus.out_full, 0);

    // 1/4 * 1/4 = 1/16: only the second product digit is 1
    cx = '{1, 0, 0, 0};
    cy = '{1, 0, 0, 0};
    pd = '{0, 1, 0, 0, 0, 0, 0, 0};
    run_op(0, 0, 0, 0);
    run_op(1, 0, 0, 5);

    // 151/256 * -109/256 = -16459/65536, hand-expanded to radix-4 digits
    cx = '{3, -3, 2, -1};
    cy = '{-2, 1, 0, 3};
    pd = '{-1, 0, 0, 0, -1, 0, -2, -3};
    run_op(1, 0, 1, 0);
    run_op(0, 0, 0, 1);

    // abort in the third RUN cycle
    issue(0, 0, 0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_mul_clear", bus.mul_clear, 0);
    check("abort_mul_x", bus.mul_x, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_out_z", bus.out_z, 0);
    reset = 1'b0;
    sb.delete();
    bus.out_ready = 1'b1;
    nv = 0;
    repeat (30) begin tick(); if (bus.out_valid) nv++; end
    bus.out_ready = 1'b0;
    check("abort_no_valid", nv, 0);

`ifdef ONLINE_SEQ_DIGCHK_EN
    cx = '{0, -4, 0, 0};
    cy = '{1, 1, 1, 1};
    run_op(0, 1, 0, 2);
`endif

    for (int t = 0; t < 500; t++) begin
      for (int i = 0; i < N; i++) begin
        cx[i] = int'($urandom_range(6)) - 3;
        cy[i] = int'($urandom_range(6)) - 3;
      end
      model_pd();
      run_op(1'($urandom_range(1)), 0, 1'($urandom_range(1)), int'($urandom_range(2)));
    end

    repeat (3) tick();
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
